m_unit_dispatch: RTL and testbench
==================================

Name: m_unit_dispatch

Overview:
Upstream issue stage for riscv_m_unit. It accepts decoded register-read instructions from the core pipeline and filters for RV32M encodings. Accepted M instructions are buffered in a small in-order FIFO and issued one at a time to the M unit using its valid/ready protocol. Each result is returned to the register-file writeback port, tagged with its destination register index.

Parameters:
DEPTH, 2, FIFO entries (power of two, >=2)
TIMEOUT, 64, maximum WAIT cycles before the outstanding operation is abandoned

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  core offers an instruction
in_ready  out  1  dispatcher can accept
in_instruction  in  32  full instruction word
in_rs1  in  32  rs1 operand value
in_rs2  in  32  rs2 operand value
illegal  out  1  one-cycle pulse: accepted word was not an M instruction
m_valid  out  1  issue strobe to M unit
m_instruction  out  32  instruction to M unit
m_rs1  out  32  operand to M unit
m_rs2  out  32  operand to M unit
m_busy  in  1  M unit busy
m_ready  in  1  M unit result valid
m_rd  in  32  M unit result
wb_valid  out  1  writeback request
wb_idx  out  5  destination register index
wb_data  out  32  result value
wb_ready  in  1  register file accepts writeback
timeout  out  1  one-cycle pulse: WAIT exceeded TIMEOUT
idle  out  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset (asynchronous, any state): FIFO emptied, FSM to IDLE, timeout counter 0. All outputs 0 except in_ready=1 and idle=1.
- Accept: a handshake occurs when in_valid && in_ready. in_ready = !fifo_full, with no same-cycle bypass, so a full FIFO blocks even when it pops in that cycle.
- Decode: a word is M iff [6:0]==7'h33 && [31:25]==7'h01.
  - M word: push {instruction, rs1, rs2}.
  - Non-M word: consumed but not pushed; illegal pulses in the following cycle.
- FSM states: IDLE, ISSUE, WAIT, WB.
  - IDLE: if FIFO non-empty && !m_busy, go to ISSUE.
  - ISSUE: m_valid=1 for exactly this cycle, FIFO head popped into the issue register, then WAIT.
  - WAIT: counter increments each cycle. On m_ready, m_rd is captured into wb_data and wb_idx=instr[11:7]. Next state is WB, or IDLE directly if the index is 0 (x0 result discarded). If the counter reaches TIMEOUT without m_ready, timeout pulses, the result is dropped, and the FSM goes to IDLE.
  - WB: wb_valid=1, with wb_idx and wb_data stable until wb_ready. Go to IDLE on wb_ready.
- m_instruction, m_rs1 and m_rs2 come from the issue register and stay stable from ISSUE through WAIT. Their value outside those states is don't-care.
- m_ready is sampled only in WAIT. The M unit asserts ready no earlier than the cycle after m_valid; m_ready in other states is ignored.
- Latency, empty FIFO: accept in cycle N, m_valid in cycle N+2. If m_ready is seen in cycle K, wb_valid rises in cycle K+1.
- Ordering: strictly in order. Only one operation is outstanding. No new issue occurs while in WAIT or WB.
- FIFO pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.
- idle = (state==IDLE) && fifo_empty.

Decomposition:
- Add to the shared M definitions header:
  - OPCODE_OP=7'h33 and FUNCT7_MULDIV=7'h01 constants.
  - A dispatch state enum {IDLE, ISSUE, WAIT, WB}.
  - The existing func3 enum, reused by benches.
- Sub-module m_dispatch_fifo: synchronous FIFO with DEPTH and WIDTH parameters, push/pop/full/empty, and asynchronous active-low reset.

Test Plan:
- MUL (funct3 0) rd=x5, rs1=rs2=0x1111FFFF, wb_ready=1 -> m_valid 2 cycles after accept; wb_valid with wb_idx=5, wb_data=0xDDDC0001.
- DIV then REM back-to-back, rs1=0xFFFFFFF3, rs2=5, rd=x6/x7, plus a third offered word -> in_ready drops after 2 accepts; writebacks in order (6, 0xFFFFFFFE) then (7, 0xFFFFFFFD); third word accepted after the first pop.
- ADD (funct7 0, opcode 0x33) -> illegal pulses once; no m_valid; FIFO empty; idle stays 1.
- DIVU rd=x0, rs1=13, rs2=5 -> m_valid issued; no wb_valid; FSM returns to IDLE after m_ready.
- wb_ready held low 10 cycles with a second entry queued -> wb_valid, wb_idx and wb_data stable; no second m_valid until the cycle after wb_ready.
- Stub M unit never asserting m_ready -> timeout pulses after 64 WAIT cycles, then the next entry issues. Separately, resetn low mid-WAIT -> all outputs at reset values immediately; queued entries lost.

Source files
------------

// File: rtl/m_unit_dispatch_pkg.sv
// Shared M-extension definitions: encoding constants, funct3 names,
// dispatcher state encoding and the buffered operation record.
package m_unit_dispatch_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'h33;
    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } m_func3_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB
    } dispatch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } m_op_t;

    // True when the word is an RV32M register-register instruction.
    function automatic logic is_m_op(input logic [31:0] word);
        return (word[6:0] == OPCODE_OP) && (word[31:25] == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/m_dispatch_fifo.sv
// Small synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module m_dispatch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer advance; writes into a full FIFO and reads from an empty one are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/m_unit_dispatch.sv
// Issue stage in front of the M unit: filters RV32M words from the core,
// queues them in order, issues one at a time and forwards each result to
// the register-file writeback port.
module m_unit_dispatch
    import m_unit_dispatch_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        illegal,
    output logic        m_valid,
    output logic [31:0] m_instruction,
    output logic [31:0] m_rs1,
    output logic [31:0] m_rs2,
    input  logic        m_busy,
    input  logic        m_ready,
    input  logic [31:0] m_rd,
    output logic        wb_valid,
    output logic [4:0]  wb_idx,
    output logic [31:0] wb_data,
    input  logic        wb_ready,
    output logic        timeout,
    output logic        idle
);

    localparam int CW = $clog2(TIMEOUT + 1);

    dispatch_state_e state;
    dispatch_state_e state_next;

    m_op_t   push_op;
    m_op_t   head_op;
    m_op_t   issue_op;
    logic    accept;
    logic    fifo_push;
    logic    fifo_pop;
    logic    fifo_full;
    logic    fifo_empty;
    logic    load_issue;
    logic    capture;
    logic    expire;
    logic    illegal_q;
    logic    timeout_q;
    logic [CW-1:0] wait_cnt;
    logic [4:0]    wb_idx_q;
    logic [31:0]   wb_data_q;

    assign in_ready  = !fifo_full;
    assign accept    = in_valid && in_ready;
    assign fifo_push = accept && is_m_op(in_instruction);
    assign push_op   = {in_instruction, in_rs1, in_rs2};

    m_dispatch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(m_op_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (resetn),
        .push      (fifo_push),
        .push_data (push_op),
        .pop       (fifo_pop),
        .pop_data  (head_op),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state and control strobes; the head is copied into the issue
    // register on the way into ISSUE and popped during ISSUE, so the FIFO
    // stays full (and in_ready low) through the issue cycle.
    always_comb begin
        state_next = state;
        load_issue = 1'b0;
        fifo_pop   = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !m_busy) begin
                    load_issue = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                fifo_pop   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (m_ready) begin
                    capture    = 1'b1;
                    state_next = (issue_op.instr[11:7] != 5'd0) ? WB : IDLE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            WB: begin
                if (wb_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue register holding the operation presented to the M unit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            issue_op <= '0;
        end else if (load_issue) begin
            issue_op <= head_op;
        end
    end

    // Counts WAIT cycles of the outstanding operation; cleared whenever WAIT is left.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (state == WAIT && state_next == WAIT) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Writeback payload, captured once and held until the register file accepts it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_idx_q  <= '0;
            wb_data_q <= '0;
        end else if (capture) begin
            wb_idx_q  <= issue_op.instr[11:7];
            wb_data_q <= m_rd;
        end
    end

    // Single-cycle event pulses, reported the cycle after the event.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            illegal_q <= accept && !is_m_op(in_instruction);
            timeout_q <= expire;
        end
    end

    assign illegal       = illegal_q;
    assign timeout       = timeout_q;
    assign m_valid       = (state == ISSUE);
    assign m_instruction = issue_op.instr;
    assign m_rs1         = issue_op.rs1;
    assign m_rs2         = issue_op.rs2;
    assign wb_valid      = (state == WB);
    assign wb_idx        = wb_idx_q;
    assign wb_data       = wb_data_q;
    assign idle          = (state == IDLE) && fifo_empty;

endmodule

// File: tb/tb_m_unit_dispatch.sv
// Directed testbench for m_unit_dispatch. The bench plays the core, the
// M unit and the register file; results fed back are hand-computed.
module tb_m_unit_dispatch;
    import m_unit_dispatch_pkg::*;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        illegal;
    logic        m_valid;
    logic [31:0] m_instruction;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    logic        m_busy;
    logic        m_ready;
    logic [31:0] m_rd;
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        timeout;
    logic        idle;

    int n_compared;
    int n_mismatched;

    m_unit_dispatch #(
        .DEPTH   (2),
        .TIMEOUT (64)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instruction (in_instruction),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .illegal        (illegal),
        .m_valid        (m_valid),
        .m_instruction  (m_instruction),
        .m_rs1          (m_rs1),
        .m_rs2          (m_rs2),
        .m_busy         (m_busy),
        .m_ready        (m_ready),
        .m_rd           (m_rd),
        .wb_valid       (wb_valid),
        .wb_idx         (wb_idx),
        .wb_data        (wb_data),
        .wb_ready       (wb_ready),
        .timeout        (timeout),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds an R-type word with opcode 0x33 (rs1=x1, rs2=x2).
    function automatic logic [31:0] r_word(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'h33};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] word, input logic [31:0] a, input logic [31:0] b);
        in_valid       = 1'b1;
        in_instruction = word;
        in_rs1         = a;
        in_rs2         = b;
    endtask

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b0; in_instruction = '0; in_rs1 = '0; in_rs2 = '0;
        m_busy = 1'b0; m_ready = 1'b0; m_rd = '0; wb_ready = 1'b1;
        tick(); tick(); #1;
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_in_ready: got %b want 1", in_ready); end
        n_compared++; if (idle !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_idle: got %b want 1", idle); end
        n_compared++; if ({m_valid, wb_valid, illegal, timeout} !== 4'b0) begin n_mismatched++; $display("[TB] FAIL rst_strobes: got %b want 0000", {m_valid, wb_valid, illegal, timeout}); end
        n_compared++; if ({m_instruction, m_rs1, m_rs2} !== 96'h0) begin n_mismatched++; $display("[TB] FAIL rst_issue_regs: got %h want 0", {m_instruction, m_rs1, m_rs2}); end
        n_compared++; if ({wb_idx, wb_data} !== 37'h0) begin n_mismatched++; $display("[TB] FAIL rst_wb_regs: got %h want 0", {wb_idx, wb_data}); end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_mul();
        logic [31:0] w;
        w = r_word(FUNCT7_MULDIV, F3_MUL, 5'd5);
        tick(); offer(w, 32'h1111FFFF, 32'h1111FFFF); wb_ready = 1'b1; #1;
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mul_accept: got %b want 1", in_ready); end
        tick(); in_valid = 1'b0; #1;
        n_compared++; if (m_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mul_early_mvalid: got %b want 0", m_valid); end
        tick(); #1;
        n_compared++; if (m_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mul_mvalid: got %b want 1", m_valid); end
        n_compared++; if (m_instruction !== w) begin n_mismatched++; $display("[TB] FAIL mul_instr: got %h want %h", m_instruction, w); end
        n_compared++; if ({m_rs1, m_rs2} !== {32'h1111FFFF, 32'h1111FFFF}) begin n_mismatched++; $display("[TB] FAIL mul_operands: got %h %h want 1111ffff 1111ffff", m_rs1, m_rs2); end
        tick(); m_ready = 1'b1; m_rd = 32'hDDDC0001; #1;
        n_compared++; if (m_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mul_mvalid_once: got %b want 0", m_valid); end
        n_compared++; if (m_instruction !== w) begin n_mismatched++; $display("[TB] FAIL mul_instr_wait: got %h want %h", m_instruction, w); end
        tick(); m_ready = 1'b0; #1;
        n_compared++; if (wb_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mul_wb_valid: got %b want 1", wb_valid); end
        n_compared++; if (wb_idx !== 5'd5) begin n_mismatched++; $display("[TB] FAIL mul_wb_idx: got %0d want 5", wb_idx); end
        n_compared++; if (wb_data !== 32'hDDDC0001) begin n_mismatched++; $display("[TB] FAIL mul_wb_data: got %h want dddc0001", wb_data); end
        tick(); #1;
        n_compared++; if ({wb_valid, idle} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL mul_done: got wb_valid,idle=%b want 01", {wb_valid, idle}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd, wr, wh;
        wd = r_word(FUNCT7_MULDIV, F3_DIV, 5'd6);
        wr = r_word(FUNCT7_MULDIV, F3_REM, 5'd7);
        wh = r_word(FUNCT7_MULDIV, F3_MULHU, 5'd8);
        wb_ready = 1'b1;
        tick(); offer(wd, 32'hFFFFFFF3, 32'd5); #1;
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_accept1: got %b want 1", in_ready); end
        tick(); offer(wr, 32'hFFFFFFF3, 32'd5); #1;
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_accept2: got %b want 1", in_ready); end
        tick(); offer(wh, 32'd3, 32'd4); #1;
        n_compared++; if (in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_full: got %b want 0", in_ready); end
        n_compared++; if ({m_valid, m_instruction} !== {1'b1, wd}) begin n_mismatched++; $display("[TB] FAIL b2b_issue_div: got %b %h want 1 %h", m_valid, m_instruction, wd); end
        n_compared++; if (m_rs1 !== 32'hFFFFFFF3) begin n_mismatched++; $display("[TB] FAIL b2b_div_rs1: got %h want fffffff3", m_rs1); end
        tick(); m_ready = 1'b1; m_rd = 32'hFFFFFFFE; #1;
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_accept3: got %b want 1", in_ready); end
        tick(); in_valid = 1'b0; m_ready = 1'b0; #1;
        n_compared++; if ({wb_valid, wb_idx, wb_data} !== {1'b1, 5'd6, 32'hFFFFFFFE}) begin n_mismatched++; $display("[TB] FAIL b2b_wb_div: got %b %0d %h want 1 6 fffffffe", wb_valid, wb_idx, wb_data); end
        tick(); #1;
        n_compared++; if ({wb_valid, m_valid} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL b2b_gap: got %b want 00", {wb_valid, m_valid}); end
        tick(); #1;
        n_compared++; if ({m_valid, m_instruction} !== {1'b1, wr}) begin n_mismatched++; $display("[TB] FAIL b2b_issue_rem: got %b %h want 1 %h", m_valid, m_instruction, wr); end
        tick(); m_ready = 1'b1; m_rd = 32'hFFFFFFFD; #1;
        tick(); m_ready = 1'b0; #1;
        n_compared++; if ({wb_valid, wb_idx, wb_data} !== {1'b1, 5'd7, 32'hFFFFFFFD}) begin n_mismatched++; $display("[TB] FAIL b2b_wb_rem: got %b %0d %h want 1 7 fffffffd", wb_valid, wb_idx, wb_data); end
        tick(); #1;
        tick(); #1;
        n_compared++; if ({m_valid, m_instruction} !== {1'b1, wh}) begin n_mismatched++; $display("[TB] FAIL b2b_issue_third: got %b %h want 1 %h", m_valid, m_instruction, wh); end
        tick(); m_ready = 1'b1; m_rd = 32'h0; #1;
        tick(); m_ready = 1'b0; #1;
        n_compared++; if ({wb_valid, wb_idx, wb_data} !== {1'b1, 5'd8, 32'h0}) begin n_mismatched++; $display("[TB] FAIL b2b_wb_third: got %b %0d %h want 1 8 0", wb_valid, wb_idx, wb_data); end
        tick(); #1;
        n_compared++; if (idle !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_idle: got %b want 1", idle); end
    endtask

    task automatic test_illegal();
        logic [31:0] w;
        w = r_word(7'h00, F3_MUL, 5'd3);
        tick(); offer(w, 32'd1, 32'd2); #1;
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ill_accept: got %b want 1", in_ready); end
        tick(); in_valid = 1'b0; #1;
        n_compared++; if (illegal !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ill_pulse: got %b want 1", illegal); end
        n_compared++; if ({idle, m_valid} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL ill_not_queued: got idle,m_valid=%b want 10", {idle, m_valid}); end
        tick(); #1;
        n_compared++; if (illegal !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ill_pulse_end: got %b want 0", illegal); end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            n_compared++; if ({m_valid, idle} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL ill_no_issue: got m_valid,idle=%b want 01", {m_valid, idle}); end
        end
    endtask

    task automatic test_x0_discard();
        logic [31:0] w;
        w = r_word(FUNCT7_MULDIV, F3_DIVU, 5'd0);
        tick(); offer(w, 32'd13, 32'd5); #1;
        tick(); in_valid = 1'b0; #1;
        tick(); #1;
        n_compared++; if ({m_valid, m_rs1, m_rs2} !== {1'b1, 32'd13, 32'd5}) begin n_mismatched++; $display("[TB] FAIL x0_issue: got %b %h %h want 1 d 5", m_valid, m_rs1, m_rs2); end
        tick(); m_ready = 1'b1; m_rd = 32'd2; #1;
        tick(); m_ready = 1'b0; #1;
        n_compared++; if ({wb_valid, idle} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL x0_back_idle: got wb_valid,idle=%b want 01", {wb_valid, idle}); end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            n_compared++; if (wb_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL x0_no_wb: got %b want 0", wb_valid); end
        end
    endtask

    task automatic test_wb_stall();
        logic [31:0] w1, w2;
        w1 = r_word(FUNCT7_MULDIV, F3_MUL, 5'd9);
        w2 = r_word(FUNCT7_MULDIV, F3_MULH, 5'd10);
        tick(); offer(w1, 32'd7, 32'd6); #1;
        tick(); offer(w2, 32'd7, 32'd6); #1;
        tick(); in_valid = 1'b0; #1;
        n_compared++; if ({m_valid, m_instruction} !== {1'b1, w1}) begin n_mismatched++; $display("[TB] FAIL stall_issue1: got %b %h want 1 %h", m_valid, m_instruction, w1); end
        tick(); wb_ready = 1'b0; m_ready = 1'b1; m_rd = 32'h0000002A; #1;
        for (int i = 0; i < 10; i++) begin
            tick(); m_ready = 1'b0; m_rd = 32'hDEADBEEF; #1;
            n_compared++; if ({wb_valid, wb_idx, wb_data} !== {1'b1, 5'd9, 32'h0000002A}) begin n_mismatched++; $display("[TB] FAIL stall_hold: cycle %0d got %b %0d %h want 1 9 2a", i, wb_valid, wb_idx, wb_data); end
            n_compared++; if (m_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stall_no_issue: cycle %0d got %b want 0", i, m_valid); end
        end
        tick(); wb_ready = 1'b1; #1;
        n_compared++; if ({wb_valid, m_valid} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL stall_release: got wb_valid,m_valid=%b want 10", {wb_valid, m_valid}); end
        tick(); #1;
        n_compared++; if ({wb_valid, m_valid} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL stall_after: got wb_valid,m_valid=%b want 00", {wb_valid, m_valid}); end
        tick(); #1;
        n_compared++; if ({m_valid, m_instruction} !== {1'b1, w2}) begin n_mismatched++; $display("[TB] FAIL stall_issue2: got %b %h want 1 %h", m_valid, m_instruction, w2); end
        tick(); m_ready = 1'b1; m_rd = 32'h0; #1;
        tick(); m_ready = 1'b0; #1;
        n_compared++; if ({wb_valid, wb_idx} !== {1'b1, 5'd10}) begin n_mismatched++; $display("[TB] FAIL stall_wb2: got %b %0d want 1 10", wb_valid, wb_idx); end
        tick(); #1;
        n_compared++; if (idle !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stall_idle: got %b want 1", idle); end
    endtask

    task automatic test_busy();
        logic [31:0] w;
        w = r_word(FUNCT7_MULDIV, F3_REMU, 5'd14);
        tick(); offer(w, 32'd17, 32'd6); m_busy = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            tick(); in_valid = 1'b0; #1;
            n_compared++; if (m_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL busy_hold: cycle %0d got %b want 0", i, m_valid); end
        end
        tick(); m_busy = 1'b0; #1;
        n_compared++; if (m_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL busy_release: got %b want 0", m_valid); end
        tick(); #1;
        n_compared++; if ({m_valid, m_instruction} !== {1'b1, w}) begin n_mismatched++; $display("[TB] FAIL busy_issue: got %b %h want 1 %h", m_valid, m_instruction, w); end
        tick(); m_ready = 1'b1; m_rd = 32'd5; #1;
        tick(); m_ready = 1'b0; #1;
        n_compared++; if ({wb_valid, wb_idx, wb_data} !== {1'b1, 5'd14, 32'd5}) begin n_mismatched++; $display("[TB] FAIL busy_wb: got %b %0d %h want 1 14 5", wb_valid, wb_idx, wb_data); end
        tick(); #1;
    endtask

    task automatic test_timeout_and_reset();
        logic [31:0] wx, wy, wz;
        logic early;
        wx = r_word(FUNCT7_MULDIV, F3_MUL, 5'd11);
        wy = r_word(FUNCT7_MULDIV, F3_MUL, 5'd12);
        wz = r_word(FUNCT7_MULDIV, F3_MUL, 5'd13);
        wb_ready = 1'b1;
        tick(); offer(wx, 32'd1, 32'd1); #1;
        tick(); offer(wy, 32'd2, 32'd2); #1;
        tick(); offer(wz, 32'd3, 32'd3); #1;
        n_compared++; if ({m_valid, in_ready} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL to_issue_x: got m_valid,in_ready=%b want 10", {m_valid, in_ready}); end
        tick(); #1;
        n_compared++; if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL to_accept_z: got %b want 1", in_ready); end
        early = timeout | m_valid;
        for (int i = 0; i < 63; i++) begin
            tick(); in_valid = 1'b0; #1;
            early = early | timeout | m_valid;
        end
        n_compared++; if (early !== 1'b0) begin n_mismatched++; $display("[TB] FAIL to_early: got %b want 0", early); end
        tick(); #1;
        n_compared++; if ({timeout, wb_valid, m_valid} !== 3'b100) begin n_mismatched++; $display("[TB] FAIL to_pulse: got timeout,wb_valid,m_valid=%b want 100", {timeout, wb_valid, m_valid}); end
        tick(); #1;
        n_compared++; if (timeout !== 1'b0) begin n_mismatched++; $display("[TB] FAIL to_pulse_end: got %b want 0", timeout); end
        n_compared++; if ({m_valid, m_instruction} !== {1'b1, wy}) begin n_mismatched++; $display("[TB] FAIL to_next_issue: got %b %h want 1 %h", m_valid, m_instruction, wy); end
        tick(); resetn = 1'b0; #1;
        n_compared++; if ({in_ready, idle} !== 2'b11) begin n_mismatched++; $display("[TB] FAIL mid_rst_ready_idle: got %b want 11", {in_ready, idle}); end
        n_compared++; if ({m_valid, wb_valid, illegal, timeout} !== 4'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_strobes: got %b want 0000", {m_valid, wb_valid, illegal, timeout}); end
        n_compared++; if ({m_instruction, wb_idx, wb_data} !== 69'h0) begin n_mismatched++; $display("[TB] FAIL mid_rst_regs: got %h want 0", {m_instruction, wb_idx, wb_data}); end
        tick(); tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            n_compared++; if ({m_valid, idle} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL mid_rst_lost: cycle %0d got m_valid,idle=%b want 01", i, {m_valid, idle}); end
        end
    endtask

    // Hard stop in case a scenario stalls the clocked sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_compared, n_mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_mul();
        test_back_to_back();
        test_illegal();
        test_x0_discard();
        test_wb_stall();
        test_busy();
        test_timeout_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
